// File: rtl/cpu_types_pkg.sv
// Shared types for the data-memory stage controller.
// Word, memory-FSM state and LR/SC reservation definitions.
package cpu_types_pkg;

    localparam int WORD_W  = 32;
    localparam int WADDR_W = WORD_W - 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memstate_t;

    typedef struct packed {
        logic               valid;
        logic [WADDR_W-1:0] addr;
    } resv_t;

endpackage

// File: rtl/mem_stage_ctrl_link_reg.sv
// LR/SC reservation register: set by LR, cleared by stores and snoops.
// match_o already accounts for a same-cycle snoop hit on the word.
module link_reg
    import cpu_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               set_i,
    input  logic [WADDR_W-1:0] set_addr_i,
    input  logic               st_i,
    input  logic [WADDR_W-1:0] st_addr_i,
    input  logic               snoop_i,
    input  logic [WADDR_W-1:0] snoop_addr_i,
    input  logic [WADDR_W-1:0] chk_addr_i,
    output logic               match_o
);

    resv_t resv_q;
    resv_t resv_d;

    // Next reservation: LR sets, then stores/snoops to that word clear it.
    always_comb begin
        resv_d = resv_q;
        if (set_i) begin
            resv_d.valid = 1'b1;
            resv_d.addr  = set_addr_i;
        end
        if (st_i && (st_addr_i == resv_d.addr)) begin
            resv_d.valid = 1'b0;
        end
        if (snoop_i && (snoop_addr_i == resv_d.addr)) begin
            resv_d.valid = 1'b0;
        end
    end

    // Reservation state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            resv_q <= '0;
        end else begin
            resv_q <= resv_d;
        end
    end

    assign match_o = resv_q.valid
                   && (chk_addr_i == resv_q.addr)
                   && !(snoop_i && (snoop_addr_i == resv_q.addr));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage dcache handshake controller (IDLE -> WAIT -> DONE).
// Define ATOMIC_EN to add LR/SC reservation support.
module mem_stage_ctrl
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  dREN_i,
    input  logic  dWEN_i,
    input  logic  atomic_i,
    input  logic  halt_i,
    input  word_t addr_i,
    input  word_t store_i,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_stall,
    output word_t load_o,
    output logic  mem_done
);

    memstate_t state_q;
    logic      ren_q;
    logic      wen_q;
    logic      done_q;
    word_t     addr_q;
    word_t     store_q;
    word_t     load_q;
    logic      memop;
    logic      sc_fail;

    assign memop = (dREN_i | dWEN_i) & ~halt_i;

`ifdef ATOMIC_EN
    logic atm_q;
    logic resv_match;
    logic lr_set;
    logic st_clr;
    logic unused;

    assign lr_set  = (state_q == WAIT) & dhit & ren_q & atm_q;
    assign st_clr  = (state_q == WAIT) & dhit & wen_q;
    assign sc_fail = atomic_i & dWEN_i & ~resv_match;
    assign unused  = ^{addr_i[1:0], snoop_addr[1:0]};

    link_reg u_link (
        .CLK          (CLK),
        .nRST         (nRST),
        .set_i        (lr_set),
        .set_addr_i   (addr_q[31:2]),
        .st_i         (st_clr),
        .st_addr_i    (addr_q[31:2]),
        .snoop_i      (snoop_inv),
        .snoop_addr_i (snoop_addr[31:2]),
        .chk_addr_i   (addr_i[31:2]),
        .match_o      (resv_match)
    );
`else
    logic unused;

    assign sc_fail = 1'b0;
    assign unused  = ^{atomic_i, snoop_inv, snoop_addr, addr_i[1:0]};
`endif

    // Request FSM with registered dcache request and result outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
`ifdef ATOMIC_EN
            atm_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (memop && sc_fail) begin
                        load_q  <= word_t'(1);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (memop) begin
                        ren_q   <= dREN_i;
                        wen_q   <= dWEN_i;
                        addr_q  <= {addr_i[31:2], 2'b00};
                        store_q <= store_i;
`ifdef ATOMIC_EN
                        atm_q   <= atomic_i;
`endif
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (dhit) begin
                        load_q  <= ren_q ? dmemload : '0;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dmemREN   = ren_q;
    assign dmemWEN   = wen_q;
    assign dmemaddr  = addr_q;
    assign dmemstore = store_q;
    assign load_o    = load_q;
    assign mem_done  = done_q;
    assign mem_stall = ((state_q == IDLE) & memop) | (state_q == WAIT);

endmodule
